// File: rtl/data_serializer.sv
// Frame serializer: start(0), 23 data bits LSB first, even parity, stop(1); BAUD_DIV cycles per bit.
// tx_line goes low the cycle after acceptance; words are accepted only in IDLE.
module data_serializer #(
  parameter int BAUD_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [22:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_line,
  output logic        busy,
  output logic        done,
  output logic [22:0] sended_data
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [4:0]  BIT_LAST  = 5'd22;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] baud_cnt;
  logic [4:0]  bit_cnt;
  logic [22:0] shift_reg;
  logic        bit_end;
  logic        accept;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        tx_ready = !rst;
        accept   = tx_valid && !rst;
        if (accept) state_nxt = START;
      end
      START:  if (bit_end) state_nxt = DATA;
      DATA:   if (bit_end && bit_cnt == BIT_LAST) state_nxt = PARITY;
      PARITY: if (bit_end) state_nxt = STOP;
      STOP: begin
        done = bit_end;
        if (bit_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx_line is loaded with the value of the bit that starts on the next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      sended_data <= '0;
      tx_line     <= 1'b1;
    end else begin
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 16'd1;

      if (accept) begin
        shift_reg   <= tx_data;
        sended_data <= tx_data;
        bit_cnt     <= '0;
        tx_line     <= 1'b0;
      end else if (bit_end) begin
        case (state)
          START: tx_line <= shift_reg[0];
          DATA: begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == BIT_LAST) begin
              tx_line <= ^sended_data;
              bit_cnt <= '0;
            end else begin
              tx_line <= shift_reg[1];
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: tx_line <= 1'b1;
        endcase
      end
    end
  end

endmodule
